// File: rtl/uart_echo_buffered.sv
// UART receiver feeding a synchronous FIFO that a UART transmitter drains, echoing bytes in order.
// Optional even parity on both directions is enabled by defining UART_ECHO_PARITY_EN.
module uart_echo_buffered #(
   parameter int clock_frequency = 12000000,
   parameter int baud_rate       = 9600,
   parameter int data_bits       = 8,
   parameter int stop_bits       = 1,
   parameter int fifo_depth      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx,
   output logic                        tx,
   output logic [$clog2(fifo_depth):0] fifo_level,
   output logic                        overflow,
   output logic                        frame_error,
   output logic                        parity_error,
   input  logic                        clear_errors
);
   localparam int div_raw = (clock_frequency + baud_rate / 2) / baud_rate;
   localparam int div     = (div_raw < 8) ? 8 : div_raw;
   localparam int cnt_w   = $clog2(stop_bits * div);
   localparam int idx_w   = $clog2(data_bits);
   localparam int addr_w  = $clog2(fifo_depth);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

   logic                  rx_meta, rxs, rxs_prev;
   rx_state_t             rx_state, rx_state_n;
   logic [cnt_w-1:0]      rx_cnt, rx_cnt_n;
   logic [idx_w-1:0]      rx_idx, rx_idx_n;
   logic [data_bits-1:0]  rx_shift, rx_shift_n;
   logic                  rx_tick, push_req, ferr_set;
   tx_state_t             tx_state, tx_state_n;
   logic [cnt_w-1:0]      tx_cnt, tx_cnt_n;
   logic [idx_w-1:0]      tx_idx, tx_idx_n;
   logic [data_bits-1:0]  tx_shift, tx_shift_n;
   logic                  tx_tick, tx_bit, pop;
   logic [data_bits-1:0]  mem [fifo_depth];
   logic [addr_w-1:0]     wr_ptr, rd_ptr;
   logic [addr_w:0]       count;
   logic                  full, empty, push, ovf_set;
`ifdef UART_ECHO_PARITY_EN
   logic                  rx_par_bad, rx_par_bad_n, perr_set, tx_par;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= rx;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_idx_n   = rx_idx;
      rx_shift_n = rx_shift;
      push_req   = 1'b0;
      ferr_set   = 1'b0;
`ifdef UART_ECHO_PARITY_EN
      rx_par_bad_n = rx_par_bad;
      perr_set     = 1'b0;
`endif
      rx_tick = (rx_cnt == '0);
      if (rx_state != RX_IDLE && !rx_tick) rx_cnt_n = rx_cnt - cnt_w'(1);
      case (rx_state)
         RX_IDLE: if (rxs_prev && !rxs) begin
            rx_state_n = RX_START;
            rx_cnt_n   = cnt_w'(div / 2 - 1);
         end
         RX_START: if (rx_tick) begin
            if (rxs) rx_state_n = RX_IDLE;
            else begin
               rx_state_n = RX_DATA;
               rx_cnt_n   = cnt_w'(div - 1);
               rx_idx_n   = '0;
            end
         end
         RX_DATA: if (rx_tick) begin
            rx_shift_n = {rxs, rx_shift[data_bits-1:1]};
            rx_cnt_n   = cnt_w'(div - 1);
            if (rx_idx == idx_w'(data_bits - 1)) begin
`ifdef UART_ECHO_PARITY_EN
               rx_state_n = RX_PARITY;
`else
               rx_state_n = RX_STOP;
`endif
            end else rx_idx_n = rx_idx + idx_w'(1);
         end
`ifdef UART_ECHO_PARITY_EN
         RX_PARITY: if (rx_tick) begin
            rx_par_bad_n = (^rx_shift) ^ rxs;
            rx_cnt_n     = cnt_w'(div - 1);
            rx_state_n   = RX_STOP;
         end
`endif
         RX_STOP: if (rx_tick) begin
            rx_state_n = RX_IDLE;
            ferr_set   = !rxs;
`ifdef UART_ECHO_PARITY_EN
            perr_set = rx_par_bad;
            push_req = rxs && !rx_par_bad;
`else
            push_req = rxs;
`endif
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
`ifdef UART_ECHO_PARITY_EN
         rx_par_bad <= 1'b0;
`endif
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_idx   <= rx_idx_n;
`ifdef UART_ECHO_PARITY_EN
         rx_par_bad <= rx_par_bad_n;
`endif
      end
   end

   always_ff @(posedge clk) rx_shift <= rx_shift_n;

   // A full FIFO still accepts a push when the transmitter pops in the same cycle.
   assign full    = (count == (addr_w + 1)'(fifo_depth));
   assign empty   = (count == '0);
   assign push    = push_req && (!full || pop);
   assign ovf_set = push_req && full && !pop;
   assign fifo_level = count;

   always_ff @(posedge clk) if (push) mem[wr_ptr] <= rx_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + addr_w'(1);
         if (pop)  rd_ptr <= rd_ptr + addr_w'(1);
         if (push && !pop)      count <= count + (addr_w + 1)'(1);
         else if (pop && !push) count <= count - (addr_w + 1)'(1);
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_idx_n   = tx_idx;
      tx_shift_n = tx_shift;
      pop        = 1'b0;
      tx_bit     = 1'b1;
      tx_tick    = (tx_cnt == '0);
      if (tx_state != TX_IDLE && !tx_tick) tx_cnt_n = tx_cnt - cnt_w'(1);
      case (tx_state)
         TX_IDLE: if (!empty) begin
            pop        = 1'b1;
            tx_shift_n = mem[rd_ptr];
            tx_cnt_n   = cnt_w'(div - 1);
            tx_state_n = TX_START;
         end
         TX_START: begin
            tx_bit = 1'b0;
            if (tx_tick) begin
               tx_state_n = TX_DATA;
               tx_cnt_n   = cnt_w'(div - 1);
               tx_idx_n   = '0;
            end
         end
         TX_DATA: begin
            tx_bit = tx_shift[0];
            if (tx_tick) begin
               tx_shift_n = tx_shift >> 1;
               tx_cnt_n   = cnt_w'(div - 1);
               if (tx_idx == idx_w'(data_bits - 1)) begin
`ifdef UART_ECHO_PARITY_EN
                  tx_state_n = TX_PARITY;
`else
                  tx_state_n = TX_STOP;
                  tx_cnt_n   = cnt_w'(stop_bits * div - 1);
`endif
               end else tx_idx_n = tx_idx + idx_w'(1);
            end
         end
`ifdef UART_ECHO_PARITY_EN
         TX_PARITY: begin
            tx_bit = tx_par;
            if (tx_tick) begin
               tx_state_n = TX_STOP;
               tx_cnt_n   = cnt_w'(stop_bits * div - 1);
            end
         end
`endif
         TX_STOP: if (tx_tick) tx_state_n = TX_IDLE;
         default: tx_state_n = TX_IDLE;
      endcase
   end

   // tx is registered, so the line follows the TX state one clock later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_idx   <= tx_idx_n;
         tx       <= tx_bit;
      end
   end

   always_ff @(posedge clk) begin
      tx_shift <= tx_shift_n;
`ifdef UART_ECHO_PARITY_EN
      if (pop) tx_par <= ^mem[rd_ptr];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         overflow    <= ovf_set  | (overflow & ~clear_errors);
         frame_error <= ferr_set | (frame_error & ~clear_errors);
      end
   end

`ifdef UART_ECHO_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_error <= 1'b0;
      else     parity_error <= perr_set | (parity_error & ~clear_errors);
   end
`else
   assign parity_error = 1'b0;
`endif
endmodule
